eh2_btb_upd_arb: RTL and testbench

Shares the single BTB/BHT write port between the two hardware threads. Each thread has its own small update queue, and a round-robin arbiter drains the queues onto the port. After reset, or on request, an init sequencer sweeps every BTB index and writes it invalid before normal updates are allowed. The block sits between the per-thread branch-resolution logic and the BTB array write port, which is indexed by the folded PC hash.

---
 rtl/eh2_btb_upd_arb_if.sv | 45 ++++
 rtl/eh2_btb_upd_arb.sv | 152 +++++++++++++++
 tb/tb_eh2_btb_upd_arb.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eh2_btb_upd_arb_if.sv
// BTB write-port arbitration bundle: per-thread update channels, array write port and sweep status.
// The master side is the branch-resolution logic / array; the slave side is the arbiter.
interface eh2_btb_upd_arb_if #(
   parameter int ADDR_W = 8,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 22
);
   logic              clear_req;
   logic              wr_stall;
   logic              upd_valid_t0;
   logic              upd_valid_t1;
   logic              upd_ready_t0;
   logic              upd_ready_t1;
   logic [ADDR_W-1:0] upd_index_t0;
   logic [ADDR_W-1:0] upd_index_t1;
   logic [TAG_W-1:0]  upd_tag_t0;
   logic [TAG_W-1:0]  upd_tag_t1;
   logic [DATA_W-1:0] upd_data_t0;
   logic [DATA_W-1:0] upd_data_t1;
   logic              flush_t0;
   logic              flush_t1;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_index;
   logic [TAG_W-1:0]  wr_tag;
   logic [DATA_W-1:0] wr_data;
   logic              wr_tid;
   logic              wr_clear;
   logic              busy;

   modport master (
      output clear_req, wr_stall,
      output upd_valid_t0, upd_valid_t1, upd_index_t0, upd_index_t1,
      output upd_tag_t0, upd_tag_t1, upd_data_t0, upd_data_t1, flush_t0, flush_t1,
      input  upd_ready_t0, upd_ready_t1,
      input  wr_en, wr_index, wr_tag, wr_data, wr_tid, wr_clear, busy
   );

   modport slave (
      input  clear_req, wr_stall,
      input  upd_valid_t0, upd_valid_t1, upd_index_t0, upd_index_t1,
      input  upd_tag_t0, upd_tag_t1, upd_data_t0, upd_data_t1, flush_t0, flush_t1,
      output upd_ready_t0, upd_ready_t1,
      output wr_en, wr_index, wr_tag, wr_data, wr_tid, wr_clear, busy
   );
endinterface

// File: rtl/eh2_btb_upd_arb.sv
// Shares the BTB/BHT write port between two threads: per-thread update FIFOs drained
// round-robin, preceded by an invalidation sweep of every index after reset or clear_req.
module eh2_btb_upd_arb #(
   parameter int ADDR_W = 8,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 22,
   parameter int DEPTH  = 2
) (
   input logic              clk,
   input logic              rst,
   eh2_btb_upd_arb_if.slave bus
);
   localparam int PW    = $clog2(DEPTH);
   localparam int ENT_W = ADDR_W + TAG_W + DATA_W;

   typedef enum logic {INIT, RUN} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic              rr_last_reg, rr_last_next;
   logic              wr_en_reg, wr_en_next;
   logic [ADDR_W-1:0] wr_index_reg, wr_index_next;
   logic [TAG_W-1:0]  wr_tag_reg, wr_tag_next;
   logic [DATA_W-1:0] wr_data_reg, wr_data_next;
   logic              wr_tid_reg, wr_tid_next;
   logic              wr_clear_reg, wr_clear_next;

   logic [1:0]        valid, flush, ready, full, empty, elig, push, pop;
   logic [ENT_W-1:0]  push_ent [2];
   logic [ENT_W-1:0]  head_ent [2];
   logic [ENT_W-1:0]  head_sel;
   logic              grant_any, grant_tid, run;

   assign run         = (state_reg == RUN);
   assign valid       = {bus.upd_valid_t1, bus.upd_valid_t0};
   assign flush       = {bus.flush_t1, bus.flush_t0};
   assign push_ent[0] = {bus.upd_index_t0, bus.upd_tag_t0, bus.upd_data_t0};
   assign push_ent[1] = {bus.upd_index_t1, bus.upd_tag_t1, bus.upd_data_t1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_q
         logic [ENT_W-1:0] mem [DEPTH];
         logic [PW:0]      wp_reg, rp_reg;

         // Extra wrap bit distinguishes full from empty when the slot pointers match.
         assign full[gi]     = (wp_reg[PW-1:0] == rp_reg[PW-1:0]) && (wp_reg[PW] != rp_reg[PW]);
         assign empty[gi]    = (wp_reg == rp_reg);
         assign ready[gi]    = run && !full[gi] && !flush[gi];
         assign push[gi]     = valid[gi] && ready[gi] && !bus.clear_req;
         assign head_ent[gi] = mem[rp_reg[PW-1:0]];

         always_ff @(posedge clk) begin
            if (rst || bus.clear_req || flush[gi]) begin
               wp_reg <= '0;
               rp_reg <= '0;
            end else begin
               if (push[gi]) wp_reg <= wp_reg + 1'b1;
               if (pop[gi])  rp_reg <= rp_reg + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (push[gi]) mem[wp_reg[PW-1:0]] <= push_ent[gi];
         end
      end
   endgenerate

   // A thread flushed this cycle gives up its turn; ties go to the thread not served last.
   assign elig      = ~empty & ~flush;
   assign grant_tid = (elig == 2'b11) ? ~rr_last_reg : elig[1];
   assign grant_any = run && !bus.wr_stall && !bus.clear_req && (elig != 2'b00);
   assign pop       = grant_any ? (grant_tid ? 2'b10 : 2'b01) : 2'b00;
   assign head_sel  = head_ent[grant_tid];

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      rr_last_next  = rr_last_reg;
      wr_en_next    = 1'b0;
      wr_index_next = wr_index_reg;
      wr_tag_next   = wr_tag_reg;
      wr_data_next  = wr_data_reg;
      wr_tid_next   = wr_tid_reg;
      wr_clear_next = wr_clear_reg;
      case (state_reg)
         INIT: begin
            if (bus.clear_req) begin
               cnt_next = '0;
            end else if (!bus.wr_stall) begin
               wr_en_next    = 1'b1;
               wr_clear_next = 1'b1;
               wr_index_next = cnt_reg;
               wr_tag_next   = '0;
               wr_data_next  = '0;
               wr_tid_next   = 1'b0;
               cnt_next      = cnt_reg + 1'b1;
               if (&cnt_reg) state_next = RUN;
            end
         end
         RUN: begin
            if (bus.clear_req) begin
               state_next = INIT;
               cnt_next   = '0;
            end else if (grant_any) begin
               wr_en_next    = 1'b1;
               wr_clear_next = 1'b0;
               wr_index_next = head_sel[ENT_W-1 -: ADDR_W];
               wr_tag_next   = head_sel[DATA_W +: TAG_W];
               wr_data_next  = head_sel[DATA_W-1:0];
               wr_tid_next   = grant_tid;
               rr_last_next  = grant_tid;
            end
         end
         default: state_next = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= INIT;
         cnt_reg      <= '0;
         rr_last_reg  <= 1'b1;
         wr_en_reg    <= 1'b0;
         wr_index_reg <= '0;
         wr_tag_reg   <= '0;
         wr_data_reg  <= '0;
         wr_tid_reg   <= 1'b0;
         wr_clear_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         rr_last_reg  <= rr_last_next;
         wr_en_reg    <= wr_en_next;
         wr_index_reg <= wr_index_next;
         wr_tag_reg   <= wr_tag_next;
         wr_data_reg  <= wr_data_next;
         wr_tid_reg   <= wr_tid_next;
         wr_clear_reg <= wr_clear_next;
      end
   end

   assign bus.upd_ready_t0 = ready[0];
   assign bus.upd_ready_t1 = ready[1];
   assign bus.wr_en        = wr_en_reg;
   assign bus.wr_index     = wr_index_reg;
   assign bus.wr_tag       = wr_tag_reg;
   assign bus.wr_data      = wr_data_reg;
   assign bus.wr_tid       = wr_tid_reg;
   assign bus.wr_clear     = wr_clear_reg;
   assign bus.busy         = !run;
endmodule

// File: tb/tb_eh2_btb_upd_arb.sv
// Bench for eh2_btb_upd_arb: random and directed traffic against a queue-based model
// of the sweep and round-robin write-port sharing.
module tb_eh2_btb_upd_arb;
   localparam int ADDR_W = 8;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 22;
   localparam int DEPTH  = 2;
   localparam int NIDX   = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;

   eh2_btb_upd_arb_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   eh2_btb_upd_arb #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference state: sweep mode/position, per-thread FIFOs, last-served thread.
   bit   m_run;
   int   m_cnt;
   bit   m_rr;
   ent_t mq0[$];
   ent_t mq1[$];
   logic              e_en, e_clr, e_tid;
   logic [ADDR_W-1:0] e_idx;
   logic [TAG_W-1:0]  e_tag;
   logic [DATA_W-1:0] e_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0;
      m_cnt = 0;
      m_rr  = 1'b1;
      mq0.delete();
      mq1.delete();
      e_en = 1'b0; e_clr = 1'b0; e_tid = 1'b0;
      e_idx = '0; e_tag = '0; e_data = '0;
   endtask

   task automatic model_step(input bit r0, input bit r1);
      ent_t e;
      bit   el0, el1, g;
      if (rst) begin
         model_reset();
         return;
      end
      e_en = 1'b0;
      if (!m_run) begin
         if (bus.clear_req) begin
            m_cnt = 0;
         end else if (!bus.wr_stall) begin
            e_en = 1'b1; e_clr = 1'b1; e_tid = 1'b0;
            e_idx = ADDR_W'(m_cnt); e_tag = '0; e_data = '0;
            m_cnt++;
            if (m_cnt == NIDX) begin
               m_run = 1'b1;
               m_cnt = 0;
            end
         end
      end else if (bus.clear_req) begin
         m_run = 1'b0;
         m_cnt = 0;
         mq0.delete();
         mq1.delete();
      end else begin
         el0 = (mq0.size() != 0) && !bus.flush_t0;
         el1 = (mq1.size() != 0) && !bus.flush_t1;
         if (!bus.wr_stall && (el0 || el1)) begin
            g = (el0 && el1) ? !m_rr : el1;
            e = g ? mq1.pop_front() : mq0.pop_front();
            e_en = 1'b1; e_clr = 1'b0; e_tid = g;
            e_idx = e.idx; e_tag = e.tag; e_data = e.data;
            m_rr = g;
         end
         if (bus.flush_t0) mq0.delete();
         if (bus.flush_t1) mq1.delete();
         if (bus.upd_valid_t0 && r0) mq0.push_back({bus.upd_index_t0, bus.upd_tag_t0, bus.upd_data_t0});
         if (bus.upd_valid_t1 && r1) mq1.push_back({bus.upd_index_t1, bus.upd_tag_t1, bus.upd_data_t1});
      end
   endtask

   // One clock: ready checked mid-cycle, model advanced at the edge, registered outputs checked after.
   task automatic cycle();
      bit r0, r1;
      @(negedge clk);
      r0 = m_run && (mq0.size() < DEPTH) && !bus.flush_t0 && !rst;
      r1 = m_run && (mq1.size() < DEPTH) && !bus.flush_t1 && !rst;
      if (!rst) begin
         chk("ready_t0", 32'(bus.upd_ready_t0), 32'(r0));
         chk("ready_t1", 32'(bus.upd_ready_t1), 32'(r1));
      end
      @(posedge clk);
      model_step(r0, r1);
      #1;
      chk("wr_en", 32'(bus.wr_en), 32'(e_en));
      chk("busy", 32'(bus.busy), 32'(!m_run));
      if (e_en) begin
         chk("wr_index", 32'(bus.wr_index), 32'(e_idx));
         chk("wr_tag", 32'(bus.wr_tag), 32'(e_tag));
         chk("wr_data", 32'(bus.wr_data), 32'(e_data));
         chk("wr_tid", 32'(bus.wr_tid), 32'(e_tid));
         chk("wr_clear", 32'(bus.wr_clear), 32'(e_clr));
      end
   endtask

   task automatic idle();
      bus.clear_req = 1'b0; bus.wr_stall = 1'b0;
      bus.upd_valid_t0 = 1'b0; bus.upd_valid_t1 = 1'b0;
      bus.flush_t0 = 1'b0; bus.flush_t1 = 1'b0;
   endtask

   task automatic rand_payload();
      bus.upd_index_t0 = ADDR_W'($urandom); bus.upd_index_t1 = ADDR_W'($urandom);
      bus.upd_tag_t0   = TAG_W'($urandom);  bus.upd_tag_t1   = TAG_W'($urandom);
      bus.upd_data_t0  = DATA_W'($urandom); bus.upd_data_t1  = DATA_W'($urandom);
   endtask

   task automatic run_sweep(input int stall_at, input int exp_len);
      int dur = 0, nwr = 0, nupd = 0, nst = 0;
      bit seen = 1'b0;
      idle();
      for (int i = 0; i < 600; i++) begin
         bus.wr_stall = !m_run && (m_cnt == stall_at) && (nst < 3);
         if (bus.wr_stall) nst++;
         bus.upd_valid_t0 = 1'($urandom);
         bus.upd_valid_t1 = 1'($urandom);
         rand_payload();
         cycle();
         if (bus.wr_en && bus.wr_clear) seen = 1'b1;
         if (seen) dur++;
         if (bus.wr_en) begin
            if (bus.wr_clear) nwr++;
            else nupd++;
         end
         if (seen && !bus.busy) break;
      end
      chk("sweep_len", 32'(dur), 32'(exp_len));
      chk("sweep_writes", 32'(nwr), 32'(NIDX));
      chk("sweep_upd", 32'(nupd), 32'd0);
      $display("[TB] sweep stall_at=%0d len=%0d clears=%0d updates=%0d", stall_at, dur, nwr, nupd);
      idle();
   endtask

   initial begin
      logic [3:0] seq;
      int         n;
      idle();
      rand_payload();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      cycle();
      cycle();
      chk("rst_busy", 32'(bus.busy), 32'd1);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      rst = 1'b0;

      run_sweep(-1, NIDX);

      // Both threads push two entries back to back.
      bus.upd_valid_t0 = 1'b1; bus.upd_valid_t1 = 1'b1; rand_payload();
      cycle();
      rand_payload();
      seq = '0; n = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         bus.upd_valid_t0 = 1'b0; bus.upd_valid_t1 = 1'b0;
         if (bus.wr_en) begin
            seq = {seq[2:0], bus.wr_tid};
            n++;
         end
      end
      chk("rr_seq", 32'(seq), 32'b0101);
      chk("rr_count", 32'(n), 32'd4);
      $display("[TB] round-robin tids=%b writes=%0d", seq, n);

      // Fill thread 0 behind a stall, then flush it with a concurrent push.
      bus.wr_stall = 1'b1; bus.upd_valid_t0 = 1'b1; rand_payload();
      cycle();
      rand_payload();
      cycle();
      chk("full_ready_t0", 32'(bus.upd_ready_t0), 32'd0);
      bus.wr_stall = 1'b0; bus.flush_t0 = 1'b1; rand_payload();
      cycle();
      idle();
      #1;
      chk("flush_ready_t0", 32'(bus.upd_ready_t0), 32'd1);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (bus.wr_en && !bus.wr_tid) n++;
      end
      chk("flush_no_wr", 32'(n), 32'd0);
      $display("[TB] flush t0: writes after flush=%0d", n);

      // Push-to-write latency on thread 1, unstalled and with one stall cycle.
      bus.upd_valid_t1 = 1'b1; rand_payload();
      cycle();
      idle();
      cycle();
      chk("lat_wr_en", 32'(bus.wr_en), 32'd1);
      chk("lat_wr_tid", 32'(bus.wr_tid), 32'd1);
      bus.upd_valid_t1 = 1'b1; rand_payload();
      cycle();
      idle();
      bus.wr_stall = 1'b1;
      cycle();
      chk("lat_stall_wr_en", 32'(bus.wr_en), 32'd0);
      bus.wr_stall = 1'b0;
      cycle();
      chk("lat_stall_wr_en2", 32'(bus.wr_en), 32'd1);
      chk("lat_stall_wr_tid", 32'(bus.wr_tid), 32'd1);
      $display("[TB] latency t1 checked, wr_data=%0h", bus.wr_data);

      // clear_req while both queues hold entries, then a sweep stalled at index 17.
      bus.wr_stall = 1'b1; bus.upd_valid_t0 = 1'b1; bus.upd_valid_t1 = 1'b1; rand_payload();
      cycle();
      rand_payload();
      cycle();
      idle();
      bus.clear_req = 1'b1;
      cycle();
      run_sweep(17, NIDX + 3);

      // Random traffic with occasional flush, stall, clear and reset.
      for (int i = 0; i < 2500; i++) begin
         rst              = ($urandom_range(0, 1999) == 0);
         bus.clear_req    = ($urandom_range(0, 799) == 0);
         bus.wr_stall     = ($urandom_range(0, 3) == 0);
         bus.upd_valid_t0 = 1'($urandom);
         bus.upd_valid_t1 = 1'($urandom);
         bus.flush_t0     = ($urandom_range(0, 15) == 0);
         bus.flush_t1     = ($urandom_range(0, 15) == 0);
         rand_payload();
         cycle();
      end
      rst = 1'b0;
      idle();
      $display("[TB] random phase done");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end
endmodule
